// File: rtl/reg_bus_arbiter_pkg.sv
// rtl/reg_bus_arbiter_pkg.sv - shared types and constants for the tile register bus arbiter
package reg_bus_arbiter_pkg;

    localparam int ID_LAST = 6;

    typedef logic [31:0] reg_data_t;

    typedef struct packed {
        logic       write;
        logic [7:0] target;
        logic [15:0] addr;
        reg_data_t  wdata;
    } reg_req_t;

    localparam reg_data_t REG_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/reg_bus_arbiter_rr_arbiter.sv
// rtl/reg_bus_arbiter_rr_arbiter.sv - combinational round-robin picker: first request at or above ptr, wrapping
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin register bus arbiter, one transaction in flight; optional REG_ARB_TIMEOUT_EN
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ-1:0][7:0]       req_target,
    input  logic [N_REQ-1:0][15:0]      req_addr,
    input  logic [N_REQ-1:0][31:0]      req_wdata,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [31:0]                 rsp_data,
    output logic                        rsp_err,
    output logic [15:0]                 reg_bus_waddr,
    output logic [31:0]                 reg_bus_wdata,
    output logic [ID_LAST-1:0]          reg_bus_wvalid,
    output logic [ID_LAST-1:0]          reg_bus_arvalid,
    output logic [15:0]                 reg_bus_araddr,
    input  logic [ID_LAST-1:0]          reg_bus_rvalid,
    input  reg_data_t [ID_LAST-1:0]     reg_bus_rdata,
    output logic [15:0]                 timeout_count
);

    localparam int PW = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    reg_req_t         req_q, req_d;
    reg_data_t        rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx;
    logic             tgt_ok;
    logic [ID_LAST-1:0] tgt_onehot;
    logic             hit_rvalid;
    reg_data_t        hit_rdata;
    logic             wait_expired;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Only the latched target's rvalid/rdata are visible; everything else on the bus is ignored.
    always_comb begin
        tgt_ok     = 1'b0;
        tgt_onehot = '0;
        hit_rvalid = 1'b0;
        hit_rdata  = '0;
        for (int i = 0; i < ID_LAST; i++) begin
            if (req_q.target == 8'(i)) begin
                tgt_ok        = 1'b1;
                tgt_onehot[i] = 1'b1;
                hit_rvalid    = reg_bus_rvalid[i];
                hit_rdata     = reg_bus_rdata[i];
            end
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] tcount_q, tcount_d;

    assign wait_expired = (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        tcount_d   = tcount_q;
        if (state_q == S_ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == S_WAIT_R) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            if (!hit_rvalid && wait_expired && tcount_q != 16'hFFFF) begin
                tcount_d = tcount_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            tcount_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            tcount_q   <= tcount_d;
        end
    end

    assign timeout_count = tcount_q;
`else
    assign wait_expired  = 1'b0;
    assign timeout_count = '0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        req_d      = req_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    owner_d      = grant_idx;
                    req_d.write  = req_write[grant_idx];
                    req_d.target = req_target[grant_idx];
                    req_d.addr   = req_addr[grant_idx];
                    req_d.wdata  = req_wdata[grant_idx];
                    ptr_d        = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rsp_data_d = '0;
                rsp_err_d  = !tgt_ok;
                state_d    = (tgt_ok && !req_q.write) ? S_WAIT_R : S_RESP;
            end
            S_WAIT_R: begin
                if (hit_rvalid) begin
                    rsp_data_d = hit_rdata;
                    state_d    = S_RESP;
                end else if (wait_expired) begin
                    rsp_data_d = REG_ARB_TIMEOUT_DATA;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            req_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE && !rst) ? grant : '0;
    assign reg_bus_wvalid  = (state_q == S_ISSUE &&  req_q.write) ? tgt_onehot : '0;
    assign reg_bus_arvalid = (state_q == S_ISSUE && !req_q.write) ? tgt_onehot : '0;
    assign reg_bus_waddr   = req_q.addr;
    assign reg_bus_araddr  = req_q.addr;
    assign reg_bus_wdata   = req_q.wdata;
    assign rsp_valid       = (state_q == S_RESP) ? (N_REQ'(1) << owner_q) : '0;
    assign rsp_data        = (state_q == S_RESP) ? rsp_data_q : '0;
    assign rsp_err         = (state_q == S_RESP) ? rsp_err_q : 1'b0;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - directed self-checking bench for reg_bus_arbiter; timeout steps need REG_ARB_TIMEOUT_EN
module tb_reg_bus_arbiter;
    import reg_bus_arbiter_pkg::*;

    localparam int N_REQ = 4;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ-1:0][7:0]   req_target;
    logic [N_REQ-1:0][15:0]  req_addr;
    logic [N_REQ-1:0][31:0]  req_wdata;
    logic [N_REQ-1:0]        rsp_valid;
    logic [31:0]             rsp_data;
    logic                    rsp_err;
    logic [15:0]             reg_bus_waddr;
    logic [31:0]             reg_bus_wdata;
    logic [ID_LAST-1:0]      reg_bus_wvalid;
    logic [ID_LAST-1:0]      reg_bus_arvalid;
    logic [15:0]             reg_bus_araddr;
    logic [ID_LAST-1:0]      reg_bus_rvalid;
    reg_data_t [ID_LAST-1:0] reg_bus_rdata;
    logic [15:0]             timeout_count;

    int total;
    int passed;

    reg_bus_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_target      (req_target),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .reg_bus_waddr   (reg_bus_waddr),
        .reg_bus_wdata   (reg_bus_wdata),
        .reg_bus_wvalid  (reg_bus_wvalid),
        .reg_bus_arvalid (reg_bus_arvalid),
        .reg_bus_araddr  (reg_bus_araddr),
        .reg_bus_rvalid  (reg_bus_rvalid),
        .reg_bus_rdata   (reg_bus_rdata),
        .timeout_count   (timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        total          = 0;
        passed         = 0;
        rst            = 1'b1;
        req_valid      = '0;
        req_write      = '0;
        req_target     = '0;
        req_addr       = '0;
        req_wdata      = '0;
        reg_bus_rvalid = '0;
        reg_bus_rdata  = '0;

        // reset state, with a request pending that must not be granted
        tick();
        tick();
        req_valid = 4'b0001;
        #1;
        chk("rst_ready",   32'(req_ready), 32'h0);
        chk("rst_rsp",     32'(rsp_valid), 32'h0);
        chk("rst_wvalid",  32'(reg_bus_wvalid), 32'h0);
        chk("rst_arvalid", 32'(reg_bus_arvalid), 32'h0);
        chk("rst_data",    rsp_data, 32'h0);
        chk("rst_err",     32'(rsp_err), 32'h0);
        chk("rst_waddr",   32'(reg_bus_waddr), 32'h0);
        chk("rst_wdata",   reg_bus_wdata, 32'h0);
        chk("rst_tcount",  32'(timeout_count), 32'h0);

        // single write: requester 0 -> target 2
        tick();
        rst           = 1'b0;
        req_write[0]  = 1'b1;
        req_target[0] = 8'd2;
        req_addr[0]   = 16'h0010;
        req_wdata[0]  = 32'h1234;
        req_valid     = 4'b0001;
        #1 chk("wr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("wr_wvalid",  32'(reg_bus_wvalid), 32'h4);
        chk("wr_waddr",   32'(reg_bus_waddr), 32'h10);
        chk("wr_wdata",   reg_bus_wdata, 32'h1234);
        chk("wr_arvalid", 32'(reg_bus_arvalid), 32'h0);
        chk("wr_early",   32'(rsp_valid), 32'h0);
        tick();
        #1;
        chk("wr_rsp",  32'(rsp_valid), 32'h1);
        chk("wr_err",  32'(rsp_err), 32'h0);
        chk("wr_data", rsp_data, 32'h0);

        // reset restarts the pointer at 0, then all four contend
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_write[i]  = 1'b1;
            req_target[i] = 8'(i);
            req_addr[i]   = 16'(16'h0100 + i);
            req_wdata[i]  = 32'(32'hA0 + i);
        end
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            #1 chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
            tick();
            #1;
            chk("rr_busy",   32'(req_ready), 32'h0);
            chk("rr_wvalid", 32'(reg_bus_wvalid), 32'(1 << (g % 4)));
            chk("rr_waddr",  32'(reg_bus_waddr), 32'(32'h100 + (g % 4)));
            tick();
            #1 chk("rr_rsp", 32'(rsp_valid), 32'(1 << (g % 4)));
            tick();
        end

        // read of target 3 with a spurious rvalid from id 1
        req_write[2]  = 1'b0;
        req_target[2] = 8'd3;
        req_addr[2]   = 16'h0020;
        req_valid     = 4'b0100;
        #1 chk("rd_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        chk("rd_arvalid", 32'(reg_bus_arvalid), 32'h8);
        chk("rd_araddr",  32'(reg_bus_araddr), 32'h20);
        chk("rd_wvalid",  32'(reg_bus_wvalid), 32'h0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            reg_bus_rvalid = '0;
            if (c == 3) begin
                reg_bus_rvalid   = 6'b000010;
                reg_bus_rdata[1] = 32'h0BAD;
            end
            if (c == 6) begin
                reg_bus_rvalid   = 6'b001000;
                reg_bus_rdata[3] = 32'hCAFE;
            end
            #1 chk("rd_wait", 32'(rsp_valid), 32'h0);
        end
        tick();
        reg_bus_rvalid = '0;
        #1;
        chk("rd_rsp",  32'(rsp_valid), 32'h4);
        chk("rd_data", rsp_data, 32'hCAFE);
        chk("rd_err",  32'(rsp_err), 32'h0);
        tick();
        #1 chk("rd_done", 32'(rsp_valid), 32'h0);

        // read of non-existent target ID_LAST
        req_write[1]  = 1'b0;
        req_target[1] = 8'(ID_LAST);
        req_valid     = 4'b0010;
        #1 chk("bad_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        chk("bad_arvalid", 32'(reg_bus_arvalid), 32'h0);
        chk("bad_wvalid",  32'(reg_bus_wvalid), 32'h0);
        tick();
        #1;
        chk("bad_rsp",  32'(rsp_valid), 32'h2);
        chk("bad_err",  32'(rsp_err), 32'h1);
        chk("bad_data", rsp_data, 32'h0);
        tick();

`ifdef REG_ARB_TIMEOUT_EN
        // no answer: expiry after 8 wait cycles
        req_write[3]  = 1'b0;
        req_target[3] = 8'd0;
        req_addr[3]   = 16'h0030;
        req_valid     = 4'b1000;
        #1 chk("to_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        #1 chk("to_arvalid", 32'(reg_bus_arvalid), 32'h1);
        for (int c = 2; c <= 9; c++) begin
            tick();
            #1 chk("to_wait", 32'(rsp_valid), 32'h0);
        end
        tick();
        #1;
        chk("to_rsp",    32'(rsp_valid), 32'h8);
        chk("to_data",   rsp_data, 32'hDEAD_BEEF);
        chk("to_err",    32'(rsp_err), 32'h1);
        chk("to_tcount", 32'(timeout_count), 32'h1);
        tick();

        // answer arrives exactly in the expiry cycle
        req_valid = 4'b1000;
        #1 chk("to2_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c == 9) begin
                reg_bus_rvalid   = 6'b000001;
                reg_bus_rdata[0] = 32'h55;
            end
            #1 chk("to2_wait", 32'(rsp_valid), 32'h0);
        end
        tick();
        reg_bus_rvalid = '0;
        #1;
        chk("to2_rsp",    32'(rsp_valid), 32'h8);
        chk("to2_data",   rsp_data, 32'h55);
        chk("to2_err",    32'(rsp_err), 32'h0);
        chk("to2_tcount", 32'(timeout_count), 32'h1);
        tick();
`endif

        // reset while waiting for a read, then a late rvalid
        req_write[0]  = 1'b0;
        req_target[0] = 8'd4;
        req_addr[0]   = 16'h0040;
        req_valid     = 4'b0001;
        #1 chk("mr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1 chk("mr_arvalid", 32'(reg_bus_arvalid), 32'h10);
        tick();
        rst = 1'b1;
        #1 chk("mr_wait", 32'(rsp_valid), 32'h0);
        tick();
        rst              = 1'b0;
        reg_bus_rvalid   = 6'b010000;
        reg_bus_rdata[4] = 32'h77;
        #1;
        chk("mr_idle_rsp",     32'(rsp_valid), 32'h0);
        chk("mr_idle_arvalid", 32'(reg_bus_arvalid), 32'h0);
        tick();
        reg_bus_rvalid = '0;
        #1 chk("mr_late", 32'(rsp_valid), 32'h0);
        tick();
        #1 chk("mr_late2", 32'(rsp_valid), 32'h0);

        // normal service after the abandoned transaction
        req_write[2]  = 1'b1;
        req_target[2] = 8'd5;
        req_addr[2]   = 16'h0055;
        req_wdata[2]  = 32'h9999;
        req_valid     = 4'b0100;
        #1 chk("post_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        chk("post_wvalid", 32'(reg_bus_wvalid), 32'h20);
        chk("post_waddr",  32'(reg_bus_waddr), 32'h55);
        chk("post_wdata",  reg_bus_wdata, 32'h9999);
        tick();
        #1;
        chk("post_rsp",    32'(rsp_valid), 32'h4);
        chk("post_err",    32'(rsp_err), 32'h0);
        chk("post_data",   rsp_data, 32'h0);
        chk("post_tcount", 32'(timeout_count), 32'h0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
